dut: RTL and testbench



---
 rtl/dut.sv | 104 ++++++++++
 tb/tb_dut.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dut.sv
// rtl/dut.sv - SPI master serial-clock generator with edge strobes
//
// Generates a burst of BITS SCK periods on clk_div after a one-cycle valid
// request seen while idle. Each SCK half-period is CLKS_PER_HALF_BIT clocks.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   valid         transfer request, sampled only while idle
//   clk_div       registered SCK, idles at CPOL
//   leading_edge  one-cycle strobe with each idle->active SCK transition
//   trailing_edge one-cycle strobe with each active->idle SCK transition

module dut #(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int BITS              = 8,
    parameter bit CPOL              = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    output logic clk_div,
    output logic leading_edge,
    output logic trailing_edge
);

    localparam int CNT_W  = $clog2(CLKS_PER_HALF_BIT);
    localparam int EDGE_W = $clog2(2 * BITS + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [EDGE_W-1:0] EDGES_INIT = EDGE_W'(2 * BITS);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] edges_q, edges_d;
    logic              clk_div_q, clk_div_d;
    logic              lead_q, lead_d;
    logic              trail_q, trail_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edges_d   = edges_q;
        clk_div_d = clk_div_q;
        lead_d    = 1'b0;
        trail_d   = 1'b0;

        case (state_q)
            IDLE: begin
                clk_div_d = CPOL;
                if (valid) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    edges_d = EDGES_INIT;
                end
            end
            default: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d     = '0;
                    clk_div_d = ~clk_div_q;
                    edges_d   = edges_q - EDGE_W'(1);
                    // Remaining-edge count starts even, so an even count
                    // marks the first transition of an SCK period.
                    if (edges_q[0] == 1'b0) begin
                        lead_d = 1'b1;
                    end else begin
                        trail_d = 1'b1;
                    end
                    if (edges_q == EDGE_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            edges_q   <= '0;
            clk_div_q <= CPOL;
            lead_q    <= 1'b0;
            trail_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edges_q   <= edges_d;
            clk_div_q <= clk_div_d;
            lead_q    <= lead_d;
            trail_q   <= trail_d;
        end
    end

    assign clk_div       = clk_div_q;
    assign leading_edge  = lead_q;
    assign trailing_edge = trail_q;

endmodule

// File: tb/tb_dut.sv
// tb/tb_dut.sv - directed self-checking bench for the SCK generator

module tb_dut;

    logic clk;
    logic rst0, valid0, clk0, lead0, trail0;
    logic rst1, valid1, clk1, lead1, trail1;

    int n_asserts = 0;
    int n_fail    = 0;

    dut #(.CLKS_PER_HALF_BIT(2), .BITS(8), .CPOL(1'b0)) u0 (
        .clk          (clk),
        .rst          (rst0),
        .valid        (valid0),
        .clk_div      (clk0),
        .leading_edge (lead0),
        .trailing_edge(trail0)
    );

    dut #(.CLKS_PER_HALF_BIT(3), .BITS(4), .CPOL(1'b1)) u1 (
        .clk          (clk),
        .rst          (rst1),
        .valid        (valid1),
        .clk_div      (clk1),
        .leading_edge (lead1),
        .trailing_edge(trail1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed {clk_div,lead,trail}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_asserts++;
        assert (got == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] outs(input int inst);
        return (inst == 0) ? {clk0, lead0, trail0} : {clk1, lead1, trail1};
    endfunction

    task automatic set_valid(input int inst, input logic v);
        if (inst == 0) valid0 = v; else valid1 = v;
    endtask

    task automatic set_rst(input int inst, input logic r);
        if (inst == 0) rst0 = r; else rst1 = r;
    endtask

    // Edge numbers are relative to E0, the edge that samples valid.
    // Transition k (1..2B) lands at edge k*H; odd k is leading.
    task automatic burst(input int inst, input int h, input int b, input logic cpol,
                         input int mid_t, input logic hold, input int abort_t);
        int       n_lead;
        int       n_trail;
        int       k;
        int       last;
        logic     ec, el, et;
        logic [2:0] o;
        n_lead  = 0;
        n_trail = 0;
        set_valid(inst, 1'b1);
        tick();
        chk($sformatf("burst%0d E0", inst), outs(inst), {cpol, 2'b00});
        last = (abort_t > 0) ? abort_t : 2 * b * h + 1;
        for (int t = 1; t <= last; t++) begin
            set_valid(inst, hold || (t == mid_t));
            if (t == abort_t) set_rst(inst, 1'b1);
            tick();
            k = t / h;
            if (t == abort_t || k > 2 * b) begin
                ec = cpol; el = 1'b0; et = 1'b0;
            end else begin
                ec = cpol ^ k[0];
                el = (t % h == 0) && k[0];
                et = (t % h == 0) && !k[0] && k >= 2;
            end
            o = outs(inst);
            if (o[1]) n_lead++;
            if (o[0]) n_trail++;
            chk($sformatf("burst%0d t=%0d", inst, t), o, {ec, el, et});
        end
        set_rst(inst, 1'b0);
        if (!hold) set_valid(inst, 1'b0);
        if (abort_t == 0) begin
            chk_int($sformatf("burst%0d lead count", inst), n_lead, b);
            chk_int($sformatf("burst%0d trail count", inst), n_trail, b);
        end
    endtask

    initial begin
        rst0 = 1'b1; valid0 = 1'b1;
        rst1 = 1'b1; valid1 = 1'b1;

        // Reset held with valid high: outputs stay at idle.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("reset0 cyc%0d", i), outs(0), 3'b000);
            chk($sformatf("reset1 cyc%0d", i), outs(1), 3'b100);
        end
        rst0 = 1'b0; valid0 = 1'b0;
        rst1 = 1'b0; valid1 = 1'b0;
        tick();
        chk("idle0", outs(0), 3'b000);
        chk("idle1", outs(1), 3'b100);

        // Single transfers on both configurations.
        burst(0, 2, 8, 1'b0, 0, 1'b0, 0);
        burst(1, 3, 4, 1'b1, 0, 1'b0, 0);

        // Request during RUN at edge 10 is ignored.
        tick();
        burst(0, 2, 8, 1'b0, 10, 1'b0, 0);
        tick();
        chk("after mid-valid idle", outs(0), 3'b000);

        // Back-to-back: valid held, re-sampled at edge 33, first rise at 35.
        burst(0, 2, 8, 1'b0, 0, 1'b1, 0);
        tick();
        chk("b2b edge34", outs(0), 3'b000);
        tick();
        chk("b2b edge35", outs(0), 3'b110);
        valid0 = 1'b0;
        rst0 = 1'b1;
        tick();
        chk("b2b reset", outs(0), 3'b000);
        rst0 = 1'b0;
        tick();

        // Reset mid-transfer, then a full burst must follow.
        burst(0, 2, 8, 1'b0, 0, 1'b0, 13);
        tick();
        chk("after abort0", outs(0), 3'b000);
        burst(0, 2, 8, 1'b0, 0, 1'b0, 0);

        burst(1, 3, 4, 1'b1, 0, 1'b0, 4);
        tick();
        chk("after abort1", outs(1), 3'b100);
        burst(1, 3, 4, 1'b1, 0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
